// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// shadow stage records, FSM encodings and the RAW match helper.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      writes;
    reg_addr_t dest;
    logic      is_load;
    logic      is_halt;
  } stage_rec_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  function automatic logic src_hit(
    input stage_rec_t s,
    input logic       use_rs,
    input reg_addr_t  rs,
    input logic       use_rt,
    input reg_addr_t  rt
  );
    return s.valid & s.writes &
           ((use_rs & (rs == s.dest)) |
            (use_rt & (rt == s.dest)));
  endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// One registered shadow record of an in-flight instruction.
// A clear loads an invalid (all-zero) record, i.e. a bubble.
module hazard_stage_rec
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  stage_rec_t d,
  output stage_rec_t q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bubble control, halt drain FSM and retire counter
// for the 5-stage 16-bit pipeline.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [1:0]       id_rs,
  input  logic [1:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_writes_reg,
  input  logic [1:0]       id_dest,
  input  logic             id_is_load,
  input  logic             id_is_jump,
  input  logic             id_is_halt,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             is_halted,
  output logic [CNT_W-1:0] num_inst
);

  stage_rec_t  id_rec;
  stage_rec_t  ex_rec;
  stage_rec_t  mem_rec;
  stage_rec_t  wb_rec;
  ctrl_state_t state;
  ctrl_state_t state_nx;

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic stall;
  logic do_branch;
  logic do_stall;
  logic do_halt;
  logic do_jump;
  logic advance;
  logic unused_rec;

  logic [CNT_W-1:0] cnt;

  assign id_rec = '{
    valid:   id_valid,
    writes:  id_writes_reg,
    dest:    id_dest,
    is_load: id_is_load,
    is_halt: id_is_halt
  };

  hazard_stage_rec u_ex (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (~advance),
    .d       (id_rec),
    .q       (ex_rec)
  );

  hazard_stage_rec u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .d       (ex_rec),
    .q       (mem_rec)
  );

  hazard_stage_rec u_wb (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .d       (mem_rec),
    .q       (wb_rec)
  );

  assign unused_rec = wb_rec.is_load;

  assign hit_ex  = src_hit(ex_rec, id_uses_rs, id_rs,
                           id_uses_rt, id_rt);
  assign hit_mem = src_hit(mem_rec, id_uses_rs, id_rs,
                           id_uses_rt, id_rt);
  assign hit_wb  = src_hit(wb_rec, id_uses_rs, id_rs,
                           id_uses_rt, id_rt);

  // Without forwarding the regfile has no write-through, so WB counts too.
  assign stall = FORWARDING
    ? (id_valid & hit_ex & ex_rec.is_load)
    : (id_valid & (hit_ex | hit_mem | hit_wb));

  assign do_branch = ex_branch_taken;
  assign do_stall  = stall & ~ex_branch_taken;
  assign do_halt   = id_valid & id_is_halt &
                     ~ex_branch_taken & ~stall;
  assign do_jump   = id_valid & id_is_jump & ~id_is_halt &
                     ~ex_branch_taken & ~stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:    if (do_halt) state_nx = DRAIN;
      DRAIN:  if (wb_rec.valid & wb_rec.is_halt) state_nx = HALTED;
      HALTED: state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    advance      = 1'b0;
    if (reset_n) begin
      unique case (state)
        RUN: begin
          unique case (1'b1)
            do_branch: begin
              if_id_flush  = 1'b1;
              id_ex_bubble = 1'b1;
            end
            do_stall: begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end
            do_halt: begin
              pc_write    = 1'b0;
              if_id_flush = 1'b1;
              advance     = 1'b1;
            end
            do_jump: begin
              if_id_flush = 1'b1;
              advance     = 1'b1;
            end
            default: advance = id_valid;
          endcase
        end
        DRAIN: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        HALTED: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  assign is_halted = (state == HALTED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (wb_rec.valid && state != HALTED) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign num_inst = cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Controller for the 5-stage 16-bit pipelined datapath (IF, ID, EX, MEM, WB). It keeps shadow records of the instructions in EX, MEM and WB. From these it drives the pipeline-register write enables, flushes and bubbles for load-use/RAW stalls, jumps and taken branches. It also runs the halt-drain FSM that produces is_halted, and counts retired instructions. It sits beside the datapath, fed by the ID-stage decode and by EX-stage bcond.

Parameters:
FORWARDING, 1, 1: EX/MEM->EX forwarding exists, so only load-use stalls; 0: stall on any RAW against valid writing records in EX, MEM or WB.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock, all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
id_valid  input  1  IF/ID holds a real instruction (not NOP/flushed)
id_rs  input  2  source register 1 of the ID instruction
id_rt  input  2  source register 2 of the ID instruction
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_writes_reg  input  1  ID instruction writes the register file
id_dest  input  2  destination register (already RegDst-resolved; 2 for JAL/JRL)
id_is_load  input  1  ID instruction is LWD
id_is_jump  input  1  JMP/JAL/JPR/JRL, target resolved in ID
id_is_halt  input  1  HLT
ex_branch_taken  input  1  EX-stage branch with bcond=1
pc_write  output  1  PC loads nextPC
if_id_write  output  1  IF/ID register loads data1
if_id_flush  output  1  IF/ID loads NOP
id_ex_bubble  output  1  ID/EX loads NOP/zero control
is_halted  output  1  pipeline drained after HLT
num_inst  output  CNT_W  instructions retired (WB valid count)

Behaviour:
- Design: one clock domain, clk; reset_n is asynchronous and active-low.
- Shadow record per stage EX/MEM/WB: {valid, writes, dest[1:0], is_load, is_halt}. Each cycle MEM<=EX and WB<=MEM. EX<=ID record when ID advances; otherwise EX<=invalid.
- Reset (async): all records invalid, state RUN, num_inst=0, is_halted=0. While in reset the outputs are pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- Hazard terms (combinational, only when id_valid):
  - src_hit(S) = S.valid & S.writes & ((id_uses_rs & id_rs==S.dest) | (id_uses_rt & id_rt==S.dest)).
  - FORWARDING=1: stall = src_hit(EX) & EX.is_load.
  - FORWARDING=0: stall = src_hit(EX) | src_hit(MEM) | src_hit(WB). The register file has no write-through.
- Priority per cycle: ex_branch_taken > stall > halt > jump > normal.
  - Branch: pc_write=1, if_id_flush=1, id_ex_bubble=1. ID instruction is squashed (a squashed HLT never enters DRAIN).
  - Stall: pc_write=0, if_id_write=0, id_ex_bubble=1. Stall is 1 cycle for load-use; up to 3 cycles with FORWARDING=0.
  - Halt (id_is_halt, state RUN): HLT advances to EX; pc_write=0, if_id_flush=1; next state DRAIN.
  - Jump: pc_write=1, if_id_flush=1, instruction advances. Jump penalty is 1 cycle.
  - Normal: pc_write=1, if_id_write=1.
- FSM RUN -> DRAIN -> HALTED:
  - In DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1. When WB.is_halt is set, next state is HALTED.
  - HALTED is terminal until reset. It holds is_halted=1 (registered) and freezes all enables at 0.
  - HLT in ID at cycle t gives is_halted=1 from cycle t+4.
- num_inst increments on every cycle with WB.valid, HLT included. It wraps modulo 2^CNT_W and holds in HALTED.
- Bubbles and flushed slots are invalid records: they never retire and never cause hazards.
- Reset mid-DRAIN returns to RUN immediately (asynchronous).

Decomposition:
- Shared package/header (alongside opcodes.v): stage-record field widths, FSM state encodings (RUN=0, DRAIN=1, HALTED=2), REG_ADDR_W=2.
- One sub-module: hazard_stage_rec, a registered shadow record with valid-clear. Instantiate it three times (EX/MEM/WB).

Test Plan:
- FORWARDING=1 test sequence:
  - LWD r1 then ADD r2,r1,r3 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; num_inst rises by 2 at the expected WB cycles.
  - ADD r1 then ADD r2,r1,r1 -> no stall. With FORWARDING=0 the same pair -> 3 stall cycles.
- Taken branch in EX on the same cycle as a load-use hazard in ID -> if_id_flush=1, id_ex_bubble=1, pc_write=1. No stall cycle; the squashed instruction is not counted.
- JMP in ID -> exactly one cycle with if_id_flush=1, pc_write=1; the following instruction is counted.
- 5 ALU ops then HLT -> is_halted=1 exactly 4 cycles after HLT is in ID, num_inst=6, and all enables 0 thereafter. Verify num_inst is stable for 10 more cycles.
- Assert reset_n low during DRAIN (async, mid-cycle) -> is_halted=0 and num_inst=0 immediately; after release, normal fetch (pc_write=1) resumes.
- Preload the counter path with 65535 retirements -> the next retirement wraps num_inst to 0.
